// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-to-1 mux and its arbiter.
package mux_pkg;

  localparam int MUX_MODE_FIXED = 0;
  localparam int MUX_MODE_RR    = 1;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester found scanning
// ptr, ptr+1, ..., N-1, 0, ..., ptr-1. Output is one-hot plus its index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  // ptr is always below N, so one conditional subtract is enough to wrap.
  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N) ? s - N : s;
  endfunction

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (en && !found && req[wrap_idx(int'(ptr), k)]) begin
        gnt[wrap_idx(int'(ptr), k)] = 1'b1;
        gnt_idx                     = SEL_W'(wrap_idx(int'(ptr), k));
        found                       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_arb.sv
// Registered N-to-1 multiplexer with per-channel valid/ready handshakes,
// fixed-select or round-robin channel choice, and a one-entry output slot.
module mux_nx1_arb
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = MUX_MODE_FIXED,
  parameter int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   select,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   m_out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   out_chan
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

  logic [WIDTH-1:0] chan_data [N];
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] ptr;
  logic             free;
  logic             grant_en;
  logic             xfer;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The slot can take new data when empty or when it empties this cycle;
  // reset masks every grant so nothing is consumed from a producer.
  assign free     = !out_valid || out_ready;
  assign grant_en = free && !rst;

  if (MODE == MUX_MODE_RR) begin : g_rr
    rr_arbiter #(
      .N     (N),
      .SEL_W (SEL_W)
    ) u_arb (
      .req     (in_valid),
      .ptr     (ptr),
      .en      (grant_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
    );

    logic unused_select;
    assign unused_select = ^select;
  end else begin : g_fixed
    // Out-of-range select values (possible for non-power-of-two N) grant nothing.
    always_comb begin
      gnt     = '0;
      gnt_idx = select;
      if (grant_en && ({1'b0, select} < (SEL_W+1)'(N)) && in_valid[select]) begin
        gnt[select] = 1'b1;
      end
    end

    logic unused_ptr;
    assign unused_ptr = ^ptr;
  end

  assign in_ready = gnt;
  assign xfer     = |gnt;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the data register is reset too, because a cleared m_out is part of
  // the visible reset state rather than a don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      m_out     <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        m_out     <= chan_data[gnt_idx];
        out_chan  <= gnt_idx;
        out_valid <= 1'b1;
        if (MODE == MUX_MODE_RR) begin
          ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Self-checking bench: fixed-select instance driven from a vector table,
// round-robin instance checked against a scoreboard of expected transfers.
module tb_mux_nx1_arb;

  localparam logic [31:0] BASE_DATA = 32'hD3C2_B1A0;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;

  logic [3:0]  fx_valid, fx_in_ready;
  logic [1:0]  fx_sel, fx_chan;
  logic        fx_oready, fx_ovalid;
  logic [7:0]  fx_out;

  logic [3:0]  rr_valid, rr_in_ready;
  logic [1:0]  rr_sel, rr_chan;
  logic        rr_oready, rr_ovalid;
  logic [7:0]  rr_out;

  int vectors;
  int miscompares;

  mux_nx1_arb #(.WIDTH(8), .N(4), .MODE(0)) u_fix (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (fx_valid),
    .in_ready  (fx_in_ready),
    .select    (fx_sel),
    .out_ready (fx_oready),
    .m_out     (fx_out),
    .out_valid (fx_ovalid),
    .out_chan  (fx_chan)
  );

  mux_nx1_arb #(.WIDTH(8), .N(4), .MODE(1)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (rr_valid),
    .in_ready  (rr_in_ready),
    .select    (rr_sel),
    .out_ready (rr_oready),
    .m_out     (rr_out),
    .out_valid (rr_ovalid),
    .out_chan  (rr_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] chan;
  } exp_t;

  exp_t sb_q[$];
  exp_t held;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [3:0]  valid;
    logic [1:0]  sel;
    logic        oready;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [7:0]  exp_out;
    logic [1:0]  exp_chan;
  } fx_vec_t;

  fx_vec_t fx_tab[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] data, input logic [3:0] valid,
                         input logic [1:0] sel, input logic oready, input logic [3:0] exp_ready,
                         input logic exp_ovalid, input logic [7:0] exp_out, input logic [1:0] exp_chan);
    fx_vec_t v;
    v.name       = name;
    v.data       = data;
    v.valid      = valid;
    v.sel        = sel;
    v.oready     = oready;
    v.exp_ready  = exp_ready;
    v.exp_ovalid = exp_ovalid;
    v.exp_out    = exp_out;
    v.exp_chan   = exp_chan;
    fx_tab.push_back(v);
  endtask

  // Called at a falling edge; drives one cycle of round-robin stimulus,
  // records the expected transfer and checks what the slot holds afterwards.
  task automatic rr_cycle(input string tag, input logic [3:0] valid, input logic oready,
                          input logic [3:0] exp_ready, input logic exp_ovalid);
    exp_t e;
    rr_valid  = valid;
    rr_oready = oready;
    #1;
    check({tag, " rr in_ready"}, 32'(rr_in_ready), 32'(exp_ready));
    for (int i = 0; i < 4; i++) begin
      if (exp_ready[i]) begin
        e.data = in_data[i*8 +: 8];
        e.chan = 2'(i);
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, " rr out_valid"}, 32'(rr_ovalid), 32'(exp_ovalid));
    if (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      held = e;
      check({tag, " rr m_out"}, 32'(rr_out), 32'(e.data));
      check({tag, " rr out_chan"}, 32'(rr_chan), 32'(e.chan));
    end else if (exp_ovalid) begin
      check({tag, " rr m_out held"}, 32'(rr_out), 32'(held.data));
      check({tag, " rr out_chan held"}, 32'(rr_chan), 32'(held.chan));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_data     = BASE_DATA;
    fx_valid    = 4'b1111;
    fx_sel      = 2'd0;
    fx_oready   = 1'b1;
    rr_valid    = 4'b1111;
    rr_sel      = 2'd0;
    rr_oready   = 1'b1;

    // Reset state, with every channel requesting and the consumer ready.
    @(posedge clk);
    @(negedge clk);
    check("reset rr in_ready", 32'(rr_in_ready), 32'h0);
    check("reset fx in_ready", 32'(fx_in_ready), 32'h0);
    check("reset rr out_valid", 32'(rr_ovalid), 32'h0);
    check("reset rr m_out", 32'(rr_out), 32'h0);
    check("reset rr out_chan", 32'(rr_chan), 32'h0);
    check("reset fx out_valid", 32'(fx_ovalid), 32'h0);
    check("reset fx m_out", 32'(fx_out), 32'h0);

    rst      = 1'b0;
    fx_valid = 4'b0000;

    // All channels valid: grants rotate 0,1,2,3,0,1 starting from reset.
    rr_cycle("rr_all0", 4'b1111, 1'b1, 4'b0001, 1'b1);
    rr_cycle("rr_all1", 4'b1111, 1'b1, 4'b0010, 1'b1);
    rr_cycle("rr_all2", 4'b1111, 1'b1, 4'b0100, 1'b1);
    rr_cycle("rr_all3", 4'b1111, 1'b1, 4'b1000, 1'b1);
    rr_cycle("rr_all4", 4'b1111, 1'b1, 4'b0001, 1'b1);
    rr_cycle("rr_all5", 4'b1111, 1'b1, 4'b0010, 1'b1);

    // Sparse requests: move ptr to 3, then 2, then the scan 2,3,0 finds 0.
    rr_cycle("rr_sparse_c2", 4'b0100, 1'b1, 4'b0100, 1'b1);
    rr_cycle("rr_sparse_c1", 4'b0010, 1'b1, 4'b0010, 1'b1);
    rr_cycle("rr_sparse_c0", 4'b0011, 1'b1, 4'b0001, 1'b1);

    // Backpressure: held output survives changing input data, then drains
    // and refills in the same cycle.
    in_data = 32'h1122_3344;
    rr_cycle("rr_stall0", 4'b1111, 1'b0, 4'b0000, 1'b1);
    in_data = 32'h5566_7788;
    rr_cycle("rr_stall1", 4'b1111, 1'b0, 4'b0000, 1'b1);
    in_data = BASE_DATA;
    rr_cycle("rr_refill", 4'b1111, 1'b1, 4'b0010, 1'b1);

    // Mid-stream reset while stalled: held data is dropped, ptr restarts at 0.
    rr_cycle("rr_prereset", 4'b1111, 1'b0, 4'b0000, 1'b1);
    rst = 1'b1;
    #1;
    check("midreset rr in_ready", 32'(rr_in_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midreset rr out_valid", 32'(rr_ovalid), 32'h0);
    check("midreset rr m_out", 32'(rr_out), 32'h0);
    check("midreset rr out_chan", 32'(rr_chan), 32'h0);
    rr_cycle("rr_postreset", 4'b1111, 1'b0, 4'b0001, 1'b1);

    rr_valid  = 4'b0000;
    rr_oready = 1'b1;

    // Fixed-select vectors, applied in order from an empty slot.
    add_vec("fx_sel2_hit",   BASE_DATA,     4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2);
    add_vec("fx_sel2_miss",  BASE_DATA,     4'b1011, 2'd2, 1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2);
    add_vec("fx_sel0_load",  BASE_DATA,     4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0);
    add_vec("fx_stall_a",    32'h1122_3344, 4'b1111, 2'd3, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    add_vec("fx_stall_b",    32'h5566_7788, 4'b1111, 2'd1, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    add_vec("fx_stall_c",    32'h99AA_BBCC, 4'b1111, 2'd2, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0);
    add_vec("fx_drain_load", BASE_DATA,     4'b1000, 2'd3, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3);
    add_vec("fx_drain_only", BASE_DATA,     4'b0000, 2'd3, 1'b1, 4'b0000, 1'b0, 8'hD3, 2'd3);

    for (int i = 0; i < fx_tab.size(); i++) begin
      in_data   = fx_tab[i].data;
      fx_valid  = fx_tab[i].valid;
      fx_sel    = fx_tab[i].sel;
      fx_oready = fx_tab[i].oready;
      #1;
      check({fx_tab[i].name, " fx in_ready"}, 32'(fx_in_ready), 32'(fx_tab[i].exp_ready));
      @(posedge clk);
      @(negedge clk);
      check({fx_tab[i].name, " fx out_valid"}, 32'(fx_ovalid), 32'(fx_tab[i].exp_ovalid));
      check({fx_tab[i].name, " fx m_out"}, 32'(fx_out), 32'(fx_tab[i].exp_out));
      check({fx_tab[i].name, " fx out_chan"}, 32'(fx_chan), 32'(fx_tab[i].exp_chan));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
